// File: rtl/xadac_vec_issue_ctrl_pkg.sv
// Shared types and sizes for the XADAC vector issue controller.
package xadac_vec_issue_ctrl_pkg;

   localparam int unsigned NoVs         = 3;
   localparam int unsigned IdWidth      = 4;
   localparam int unsigned VecAddrWidth = 5;
   localparam int unsigned SbLen        = 2 ** IdWidth;
   localparam int unsigned NoVec        = 2 ** VecAddrWidth;

   // Count of busy IDs needs one extra bit so a full scoreboard is representable
   typedef logic [IdWidth:0]        SizeT;
   typedef logic [IdWidth-1:0]      IdT;
   typedef logic [VecAddrWidth-1:0] VecAddrT;

   typedef struct packed {
      IdT                 id;
      VecAddrT [NoVs-1:0] vs_addr;
      logic [NoVs-1:0]    vs_read;
      VecAddrT            vd_addr;
      logic               vd_clobber;
   } IssInfoT;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } IssStateT;

endpackage

// File: rtl/xadac_vec_issue_ctrl_id_table.sv
// Per-transaction-ID tracking: busy flag plus the destination register each
// in-flight ID will eventually release. Retire of an idle ID flags an error.
module xadac_id_table #(
   parameter int unsigned IdWidth      = 4,
   parameter int unsigned VecAddrWidth = 5
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      alloc_valid,
   input  logic [IdWidth-1:0]        alloc_id,
   input  logic [VecAddrWidth-1:0]   alloc_vd,
   input  logic                      alloc_vd_vld,
   input  logic                      ret_valid,
   input  logic [IdWidth-1:0]        ret_id,
   output logic [(2**IdWidth)-1:0]   busy,
   output logic                      ret_hit,
   output logic [VecAddrWidth-1:0]   ret_vd,
   output logic                      ret_vd_vld,
   output logic                      err
);

   localparam int unsigned SbDepth = 2 ** IdWidth;

   logic [SbDepth-1:0]      busy_q;
   logic [VecAddrWidth-1:0] vd_q [SbDepth];
   logic [SbDepth-1:0]      vd_vld_q;
   logic                    err_q;

   assign busy       = busy_q;
   assign ret_hit    = ret_valid & busy_q[ret_id];
   assign ret_vd     = vd_q[ret_id];
   assign ret_vd_vld = vd_vld_q[ret_id];
   assign err        = err_q;

   // Allocate and retire never name the same ID in one cycle because the
   // issue side stalls on a busy ID, so the two updates are independent.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q   <= '0;
         vd_q     <= '{default: '0};
         vd_vld_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (ret_hit) begin
            busy_q[ret_id] <= 1'b0;
         end
         if (alloc_valid) begin
            busy_q[alloc_id]   <= 1'b1;
            vd_q[alloc_id]     <= alloc_vd;
            vd_vld_q[alloc_id] <= alloc_vd_vld;
         end
         err_q <= ret_valid & ~busy_q[ret_id];
      end
   end

endmodule

// File: rtl/xadac_vec_issue_ctrl.sv
// Issue scheduler: stalls decoded vector instructions on register hazards,
// duplicate IDs, a full scoreboard or drain, and tracks pending writes.
module xadac_vec_issue_ctrl #(
   parameter int unsigned NoVs         = xadac_vec_issue_ctrl_pkg::NoVs,
   parameter int unsigned IdWidth      = xadac_vec_issue_ctrl_pkg::IdWidth,
   parameter int unsigned VecAddrWidth = xadac_vec_issue_ctrl_pkg::VecAddrWidth
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           iss_valid_i,
   output logic                           iss_ready_o,
   input  logic [IdWidth-1:0]             iss_id_i,
   input  logic [NoVs*VecAddrWidth-1:0]   iss_vs_addr_i,
   input  logic [NoVs-1:0]                iss_vs_read_i,
   input  logic [VecAddrWidth-1:0]        iss_vd_addr_i,
   input  logic                           iss_vd_clobber_i,
   output logic                           exe_valid_o,
   input  logic                           exe_ready_i,
   input  logic                           ret_valid_i,
   input  logic [IdWidth-1:0]             ret_id_i,
   input  logic                           drain_i,
   output logic                           drained_o,
   output logic [IdWidth:0]               inflight_o,
   output logic                           err_o
);

   import xadac_vec_issue_ctrl_pkg::*;

   localparam int unsigned SbDepth  = 2 ** IdWidth;
   localparam int unsigned VecDepth = 2 ** VecAddrWidth;

   IssInfoT                 info;
   IssStateT                state_q, state_d;
   logic [VecDepth-1:0]     vd_pend_q;
   logic [IdWidth:0]        inflight_q;
   logic [SbDepth-1:0]      id_busy;
   logic                    ret_hit;
   logic [VecAddrWidth-1:0] ret_vd;
   logic                    ret_vd_vld;
   logic                    raw_hazard;
   logic                    waw_hazard;
   logic                    dup_id;
   logic                    sb_full;
   logic                    stall;
   logic                    issue_fire;

   // Bundle the decode payload into the shared issue-info record
   always_comb begin
      info            = '0;
      info.id         = iss_id_i;
      info.vs_addr    = iss_vs_addr_i;
      info.vs_read    = iss_vs_read_i;
      info.vd_addr    = iss_vd_addr_i;
      info.vd_clobber = iss_vd_clobber_i;
   end

   // Read-after-write: any enabled source names a register with a write pending
   always_comb begin
      raw_hazard = 1'b0;
      for (int k = 0; k < int'(NoVs); k++) begin
         if (info.vs_read[k] && vd_pend_q[info.vs_addr[k]]) begin
            raw_hazard = 1'b1;
         end
      end
   end

   assign waw_hazard  = info.vd_clobber & vd_pend_q[info.vd_addr];
   assign dup_id      = id_busy[info.id];
   assign sb_full     = (inflight_q == (IdWidth+1)'(SbDepth));
   assign stall       = raw_hazard | waw_hazard | dup_id | sb_full | (state_q == DRAIN);
   assign exe_valid_o = iss_valid_i & ~stall;
   assign iss_ready_o = exe_ready_i & ~stall;
   assign issue_fire  = iss_valid_i & iss_ready_o;
   assign drained_o   = (state_q == DRAIN) & (inflight_q == '0);
   assign inflight_o  = inflight_q;

   xadac_id_table #(
      .IdWidth      (IdWidth),
      .VecAddrWidth (VecAddrWidth)
   ) u_id_table (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .alloc_valid  (issue_fire),
      .alloc_id     (info.id),
      .alloc_vd     (info.vd_addr),
      .alloc_vd_vld (info.vd_clobber),
      .ret_valid    (ret_valid_i),
      .ret_id       (ret_id_i),
      .busy         (id_busy),
      .ret_hit      (ret_hit),
      .ret_vd       (ret_vd),
      .ret_vd_vld   (ret_vd_vld),
      .err          (err_o)
   );

   // Pending-write bitmap: the WAW check guarantees set and clear never collide
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vd_pend_q <= '0;
      end else begin
         if (ret_hit && ret_vd_vld) begin
            vd_pend_q[ret_vd] <= 1'b0;
         end
         if (issue_fire && info.vd_clobber) begin
            vd_pend_q[info.vd_addr] <= 1'b1;
         end
      end
   end

   // In-flight count; simultaneous issue and retire cancel out
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inflight_q <= '0;
      end else begin
         case ({issue_fire, ret_hit})
            2'b10:   inflight_q <= inflight_q + (IdWidth+1)'(1);
            2'b01:   inflight_q <= inflight_q - (IdWidth+1)'(1);
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   // Drain FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Drain FSM next state follows drain_i one cycle late
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (drain_i)  state_d = DRAIN;
         DRAIN:   if (!drain_i) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

endmodule
